// File: rtl/hawk_axird_arbiter.sv
// Purpose : round-robin share of the single Hawk AXI read master among N_REQ requesters, one burst in flight.
// Latency : request seen in IDLE -> m_arvalid next cycle; R beats pass through combinationally (0 cycles).
// Backpressure: AR held stable until m_arready; m_rready follows the granted requester's rsp_rready.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/addr/arlen/ready     per-requester AR request (addr/arlen packed, requester i at [i*W +: W])
//   rsp_valid/rdata/rresp/rlast    R beat steered to the granted requester (data/resp/last broadcast)
//   rsp_rready                     per-requester R ready
//   m_ar*, m_addr, m_r*            AXI read master AR/R channels
//   gnt_id, busy, len_err          grant index (valid while busy), activity, sticky burst-length error
module hawk_axird_arbiter #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 8,
  parameter int DATA_W = 512,
  parameter int RESP_W = 2,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*LEN_W-1:0]  req_arlen,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic [RESP_W-1:0]       rsp_rresp,
  output logic                    rsp_rlast,
  input  logic [N_REQ-1:0]        rsp_rready,
  output logic                    m_arvalid,
  output logic [ADDR_W-1:0]       m_addr,
  output logic [LEN_W-1:0]        m_arlen,
  input  logic                    m_arready,
  input  logic                    m_rvalid,
  input  logic [DATA_W-1:0]       m_rdata,
  input  logic [RESP_W-1:0]       m_rresp,
  input  logic                    m_rlast,
  output logic                    m_rready,
  output logic [ID_W-1:0]         gnt_id,
  output logic                    busy,
  output logic                    len_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  // Registered AR request of the current grant.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  arlen;
  } ar_req_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] gnt_q;
  ar_req_t         ar_q;
  logic [LEN_W:0]  beat_cnt_q;
  logic            len_err_q;

  logic            pick_vld;
  logic [ID_W-1:0] pick_idx;
  ar_req_t         pick_req;
  logic [N_REQ-1:0] gnt_oh;
  logic            gnt_rready;
  logic            ar_hs;
  logic            r_hs;

  // Round-robin pick: first pass takes the lowest valid index at or above
  // rr_ptr; if none, the second pass wraps and takes the lowest valid index.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    pick_req = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!pick_vld && req_valid[i] && (ID_W'(i) >= rr_ptr_q)) begin
        pick_vld       = 1'b1;
        pick_idx       = ID_W'(i);
        pick_req.addr  = req_addr[i*ADDR_W +: ADDR_W];
        pick_req.arlen = req_arlen[i*LEN_W +: LEN_W];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!pick_vld && req_valid[i]) begin
        pick_vld       = 1'b1;
        pick_idx       = ID_W'(i);
        pick_req.addr  = req_addr[i*ADDR_W +: ADDR_W];
        pick_req.arlen = req_arlen[i*LEN_W +: LEN_W];
      end
    end
  end

  assign gnt_oh     = N_REQ'(1) << gnt_q;
  assign gnt_rready = |(rsp_rready & gnt_oh);
  assign ar_hs      = (state_q == ADDR) && m_arready;
  assign r_hs       = (state_q == DATA) && m_rvalid && gnt_rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    rsp_valid = '0;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = ADDR;
        end
      end
      ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) begin
          req_ready = gnt_oh;
          state_d   = DATA;
        end
      end
      DATA: begin
        m_rready  = gnt_rready;
        rsp_valid = m_rvalid ? gnt_oh : '0;
        // rlast alone ends the burst, whatever the beat count says.
        if (m_rvalid && gnt_rready && m_rlast) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      ar_q       <= '0;
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      // Latch the request in IDLE; later changes on req_* are ignored.
      if (state_q == IDLE && pick_vld) begin
        gnt_q <= pick_idx;
        ar_q  <= pick_req;
      end

      if (ar_hs) begin
        beat_cnt_q <= '0;
      end else if (r_hs && (beat_cnt_q != '1)) begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end

      if (r_hs && m_rlast) begin
        // beat_cnt still counts the beats before this one, so a correct
        // burst of arlen+1 beats has beat_cnt == arlen here.
        if (beat_cnt_q != {1'b0, ar_q.arlen}) begin
          len_err_q <= 1'b1;
        end
        // The requester just served drops to lowest priority.
        rr_ptr_q <= (gnt_q == ID_W'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
      end
    end
  end

  assign m_addr    = ar_q.addr;
  assign m_arlen   = ar_q.arlen;
  assign rsp_rdata = m_rdata;
  assign rsp_rresp = m_rresp;
  assign rsp_rlast = m_rlast;
  assign gnt_id    = gnt_q;
  assign busy      = (state_q != IDLE);
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_hawk_axird_arbiter.sv
// Purpose : randomized and directed bench for hawk_axird_arbiter against a transaction-level model.
// Latency : model expects AR one cycle after a request is seen idle, R beats with zero latency.
// Backpressure: bench acts as requesters and as the AXI read master, randomizing arready/rvalid/rready.
module tb_hawk_axird_arbiter;
  localparam int N  = 3;
  localparam int AW = 64;
  localparam int LW = 8;
  localparam int DW = 512;
  localparam int RW = 2;
  localparam int IW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*LW-1:0] req_arlen = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic [RW-1:0]   rsp_rresp;
  logic            rsp_rlast;
  logic [N-1:0]    rsp_rready = '0;
  logic            m_arvalid;
  logic [AW-1:0]   m_addr;
  logic [LW-1:0]   m_arlen;
  logic            m_arready = 1'b0;
  logic            m_rvalid = 1'b0;
  logic [DW-1:0]   m_rdata = '0;
  logic [RW-1:0]   m_rresp = '0;
  logic            m_rlast = 1'b0;
  logic            m_rready;
  logic [IW-1:0]   gnt_id;
  logic            busy;
  logic            len_err;

  always #5 clk = ~clk;

  hawk_axird_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW), .RESP_W(RW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_arlen(req_arlen), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rresp(rsp_rresp), .rsp_rlast(rsp_rlast),
    .rsp_rready(rsp_rready),
    .m_arvalid(m_arvalid), .m_addr(m_addr), .m_arlen(m_arlen), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rready(m_rready),
    .gnt_id(gnt_id), .busy(busy), .len_err(len_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: ph 0 = no grant, 1 = AR offered, 2 = burst in flight.
  logic [N-1:0]  pend = '0;
  logic [AW-1:0] a_r [N];
  logic [LW-1:0] l_r [N];
  int            ph = 0, g = 0, rr = 0;
  int            beats_seen = 0, nbeats = 0, burst_no = 0, over = 0, last_beats = 0;
  logic [AW-1:0] lat_addr = '0;
  int            lat_len = 0;
  bit            exp_lerr = 0, tog = 0, refill = 0, auto_req = 0;
  int            ar_mode = 1, rv_mode = 1, rr_mode = 1;
  int            grant_log[$];

  function automatic int pick(input logic [N-1:0] p, input int from);
    for (int k = 0; k < N; k++) begin
      if (p[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  // One clock cycle: drive at posedge+1, sample at posedge+2, update model.
  task automatic step();
    logic [N-1:0]  exp_rdy;
    logic [N-1:0]  exp_rsp;
    logic [DW-1:0] exp_d;
    logic          hs;
    req_valid = pend;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = a_r[i];
      req_arlen[i*LW +: LW] = l_r[i];
    end
    case (ar_mode)
      1:       m_arready = 1'b1;
      2:       m_arready = 1'b0;
      default: m_arready = ($urandom_range(0, 2) != 0);
    endcase
    m_rvalid = (ph == 2) && (rv_mode == 1 || $urandom_range(0, 3) != 0);
    m_rlast  = (ph == 2) && (beats_seen == nbeats - 1);
    exp_d    = {8{{32'(burst_no), 32'(beats_seen)}}};
    m_rdata  = exp_d;
    m_rresp  = RW'($urandom_range(0, 3));
    rsp_rready = N'($urandom);
    if (rr_mode == 1) rsp_rready = '1;
    else if (rr_mode == 2 && ph == 2) rsp_rready[g] = tog;
    #1;
    check("busy", busy, ph != 0);
    check("m_arvalid", m_arvalid, ph == 1);
    if (ph != 0) check("gnt_id", gnt_id, g);
    if (ph == 1) begin
      check("m_addr", m_addr, lat_addr);
      check("m_arlen", m_arlen, lat_len);
    end
    exp_rdy = (ph == 1 && m_arready) ? N'(1 << g) : '0;
    check("req_ready", req_ready, exp_rdy);
    check("m_rready", m_rready, (ph == 2) ? rsp_rready[g] : 1'b0);
    exp_rsp = (ph == 2 && m_rvalid) ? N'(1 << g) : '0;
    check("rsp_valid", rsp_valid, exp_rsp);
    if (ph == 2 && m_rvalid) begin
      check("rdata_ok", rsp_rdata == exp_d, 1'b1);
      check("rresp", rsp_rresp, m_rresp);
      check("rlast", rsp_rlast, m_rlast);
    end
    check("len_err", len_err, exp_lerr);

    hs = (ph == 2) && m_rvalid && rsp_rready[g];
    case (ph)
      0: if (pend != '0) begin
        g        = pick(pend, rr);
        lat_addr = a_r[g];
        lat_len  = l_r[g];
        grant_log.push_back(g);
        ph       = 1;
      end
      1: if (m_arready) begin
        pend[g]    = refill;
        beats_seen = 0;
        nbeats     = (over > 0) ? over : lat_len + 1;
        over       = 0;
        tog        = 1;
        ph         = 2;
      end
      default: begin
        if (hs) begin
          beats_seen++;
          if (m_rlast) begin
            if (beats_seen != lat_len + 1) exp_lerr = 1;
            last_beats = beats_seen;
            rr = (g + 1) % N;
            burst_no++;
            ph = 0;
          end
        end
        if (rr_mode == 2) tog = ~tog;
      end
    endcase
    if (auto_req) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          a_r[i]  = {$urandom, $urandom};
          l_r[i]  = LW'($urandom_range(0, 7));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((ph != 0 || pend != '0) && n < budget) begin
      step();
      n++;
    end
    check("drain_done", (ph == 0 && pend == '0), 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; rsp_rready = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ph = 0; rr = 0; exp_lerr = 0; pend = '0; beats_seen = 0; tog = 0; over = 0;
    grant_log.delete();
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_arvalid", m_arvalid, 1'b0);
    check("rst_m_rready", m_rready, 1'b0);
    check("rst_req_ready", req_ready, '0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_gnt_id", gnt_id, '0);
    check("rst_len_err", len_err, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin
      a_r[i] = '0;
      l_r[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single request from requester 1, one beat.
    a_r[1] = 64'h0000_00FF_F620_0000;
    l_r[1] = 8'd0;
    pend   = 3'b010;
    ar_mode = 1; rv_mode = 1; rr_mode = 1;
    drain(50);
    check("single_gnt", grant_log[0], 1);
    check("single_beats", last_beats, 1);
    check("single_lerr", len_err, 1'b0);

    // All three held valid, arlen 3: grant order 0,1,2,0,1,2.
    do_reset();
    for (int i = 0; i < N; i++) begin
      a_r[i] = 64'h1000 * (i + 1);
      l_r[i] = 8'd3;
    end
    pend = 3'b111;
    refill = 1;
    n = 0;
    while (grant_log.size() < 6 && n < 200) begin
      step();
      n++;
    end
    refill = 0;
    drain(200);
    check("rr_count", grant_log.size() >= 6, 1'b1);
    if (grant_log.size() >= 6) begin
      for (int i = 0; i < 6; i++) check($sformatf("rr_order_%0d", i), grant_log[i], i % 3);
    end

    // AR backpressure: arready low 5 cycles, other requester changes meanwhile.
    a_r[0] = 64'hDEAD_BEEF_0000_0040;
    l_r[0] = 8'd2;
    pend   = 3'b001;
    ar_mode = 2;
    n = 0;
    while (ph != 1 && n < 20) begin
      step();
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        pend[2] = 1'b1;
        a_r[2]  = {$urandom, $urandom};
        l_r[2]  = 8'd1;
      end
      step();
    end
    ar_mode = 1;
    drain(100);
    check("bp_gnt0", grant_log[grant_log.size() - 2], 0);
    check("bp_gnt1", grant_log[grant_log.size() - 1], 2);

    // R backpressure: granted rsp_rready toggles, 8 beats.
    a_r[1] = 64'h0000_0000_0000_8000;
    l_r[1] = 8'd7;
    pend   = 3'b010;
    rr_mode = 2;
    drain(100);
    check("rbp_beats", last_beats, 8);
    check("rbp_lerr", len_err, 1'b0);

    // Randomized traffic with random handshakes.
    auto_req = 1; ar_mode = 0; rv_mode = 0; rr_mode = 0;
    repeat (1500) step();
    auto_req = 0;
    drain(500);
    check("rand_lerr", len_err, 1'b0);

    // Length mismatch: arlen 3, rlast on 2nd beat; then too many beats.
    ar_mode = 1; rv_mode = 1; rr_mode = 1;
    l_r[0] = 8'd3;
    pend   = 3'b001;
    over   = 2;
    drain(50);
    check("mm_lerr", len_err, 1'b1);
    check("mm_beats", last_beats, 2);
    l_r[1] = 8'd1;
    pend   = 3'b010;
    over   = 4;
    drain(50);
    check("mm_long_beats", last_beats, 4);
    l_r[2] = 8'd1;
    pend   = 3'b100;
    drain(50);
    check("mm_sticky", len_err, 1'b1);

    // Reset mid-DATA: rr moved to 1, then requester 2 cut after 2 of 4 beats.
    do_reset();
    l_r[0] = 8'd1;
    pend   = 3'b001;
    drain(50);
    l_r[2] = 8'd3;
    pend   = 3'b100;
    n = 0;
    while (!(ph == 2 && beats_seen == 2) && n < 50) begin
      step();
      n++;
    end
    check("mid_reached", (ph == 2 && beats_seen == 2), 1'b1);
    do_reset();
    l_r[0] = 8'd1;
    l_r[2] = 8'd1;
    pend   = 3'b101;
    drain(100);
    check("rst_rr_gnt", grant_log[0], 0);
    check("rst_rr_gnt2", grant_log[1], 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
